sevenseg_frame_decoder: RTL and testbench
=========================================

// Module: sevenseg_frame_decoder
// PURPOSE
//  Receive side of the multiplexed 7-segment display interface (seg/an, both active-low).
//  Samples the anode/segment lines and deglitches them across mux switching.
//  Decodes each digit glyph back to BCD and emits one complete 4-digit frame per refresh cycle.
//  Used in benches and on-board self-check to read back what the stopwatch display actually shows.
// PARAMETERS
//  STABLE_CYCLES   16        cycles {an,seg} must stay unchanged before a digit is captured (>=2)
//  TIMEOUT_CYCLES  1048576   cycles without any capture before stall asserts
//  CNT_W           21        width of the stability and timeout counters; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1   single system clock
//  reset          in   1   asynchronous, active-high
//  seg            in   7   {g,f,e,d,c,b,a}, active-low
//  an             in   4   anode enables, active-low; an[0] = rightmost digit
//  frame_digits   out  16  {d3,d2,d1,d0} BCD; a blank digit reads 4'hF
//  frame_blank    out  4   per-digit blank flag for the last frame
//  frame_valid    out  1   1-cycle pulse; the frame_* outputs were updated on this edge
//  frame_count    out  16  completed frames, wraps 16'hFFFF -> 0
//  multi_an_err   out  1   sticky: a stable an had more than one bit low
//  glyph_err      out  1   sticky: a stable single-anode seg was not a legal glyph
//  stall          out  1   no capture for TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (async): every output is 0. s_an=4'hF, s_seg=7'h7F. stab_cnt, to_cnt and seen_mask are 0.
//   The working digits are 0.
//  Sampling: every edge, s_an<=an and s_seg<=seg.
//   If {an,seg}!={s_an,s_seg}, stab_cnt<=0.
//   Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
//  Capture event: the edge on which stab_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES.
//   It fires exactly once per stable episode.
//   Latency: STABLE_CYCLES edges after the first edge that samples the new value.
//  At a capture event, classified on s_an:
//   - 4'b1111 (all off): ignored. No error. No capture for timeout purposes.
//   - exactly one bit low (index i): the glyph is decoded.
//     Legal glyphs: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//     7=1111000 8=0000000 9=0010000, and blank=1111111.
//     Legal: work_digit[i]<=value (blank gives 4'hF, blank bit set) and seen_mask[i]<=1.
//     Illegal: glyph_err<=1; work_digit[i] and seen_mask are unchanged.
//   - two or more bits low: multi_an_err<=1. Nothing else changes.
//  Repeat anode before the frame completes: overwrite work_digit[i]; seen_mask is unchanged.
//  Frame completion: a legal capture that makes seen_mask==4'b1111 does all of the following
//   on the same edge, including the completing digit:
//   frame_digits/frame_blank<=working set, frame_valid=1 for one cycle, frame_count+1, seen_mask<=0.
//  Timeout: to_cnt clears on every legal or illegal single-anode capture.
//   Otherwise it increments, saturating.
//   stall=1 while to_cnt==TIMEOUT_CYCLES.
//   A capture on the same edge as the timeout wins: stall stays 0.
//  Sticky errors clear only on reset.
//  Reset mid-frame discards the partial frame.
//  Inputs are assumed synchronous to clk; no synchronizer is included.
// STRUCTURE
//  sevenseg_pkg: glyph localparams (GLYPH_0..GLYPH_9, GLYPH_BLANK), SEG_W=7, AN_W=4, DIGIT_BLANK=4'hF.
//  Sub-module sevenseg_glyph_decode: combinational seg[6:0] -> {legal, blank, bcd[3:0]}.
//   The same table serves the display encoder's checks.
//  Top: sample registers, stability counter, anode classifier, working digit/mask regs,
//   frame output regs, timeout counter.
// TESTING
//  1 Scan digits 1,2,3,4 on an[0..3], 20 cycles each (STABLE=16)
//    -> one frame_valid pulse after the an[3] capture; frame_digits=16'h4321, frame_blank=0, frame_count=1.
//  2 Hold an=1110, seg=1111001 for exactly 15 cycles, then switch digits
//    -> no capture; seen_mask stays 0; no frame_valid.
//  3 1-cycle seg glitch inside a 20-cycle dwell -> stab_cnt restarts; a single capture occurs.
//    The glitch value is never captured.
//  4 an=1100, stable 20 cycles -> multi_an_err=1 and stays 1 through later clean frames until reset.
//  5 seg=1111111 on an[2] within an otherwise clean scan of 5,6,(blank),8
//    -> frame_digits=16'h8F65, frame_blank=4'b0100. Then seg=0111111 stable -> glyph_err=1.
//  6 TIMEOUT=64: hold an=1111 for 100 cycles -> stall=1 from cycle 64.
//    The next legal capture clears stall on the same edge.
//    Assert reset mid-scan -> all outputs 0 immediately; the following scan needs all 4 digits anew.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and helpers for the 7-segment frame decoder
// Purpose: glyph patterns ({g,f,e,d,c,b,a}, active-low), bus widths, blank code,
//          and a helper that counts active (low) anode bits.
// Ports:   none (package)
package sevenseg_pkg;

   localparam int SEG_W = 7;
   localparam int AN_W  = 4;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

   // Number of enabled anodes; anodes are active-low.
   function automatic logic [2:0] count_low(input logic [AN_W-1:0] an);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < AN_W; i++) begin
         if (!an[i]) n = n + 3'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/sevenseg_frame_decoder_if.sv
// rtl/sevenseg_frame_decoder_if.sv - display-side inputs and frame-side outputs of the decoder
// Purpose: bundles the sampled display lines and the decoded frame/status outputs.
// Signals: seg[6:0], an[3:0]       display lines, active-low (driven by master)
//          frame_digits[15:0]      {d3,d2,d1,d0} BCD, blank = 4'hF
//          frame_blank[3:0]        per-digit blank flags
//          frame_valid             1-cycle frame update pulse
//          frame_count[15:0]       completed frames, wrapping
//          multi_an_err, glyph_err sticky error flags
//          stall                   no capture for the timeout period
// Modports: master = display side / observer, slave = decoder
interface sevenseg_frame_decoder_if;
   import sevenseg_pkg::*;

   logic [SEG_W-1:0] seg;
   logic [AN_W-1:0]  an;
   logic [15:0]      frame_digits;
   logic [3:0]       frame_blank;
   logic             frame_valid;
   logic [15:0]      frame_count;
   logic             multi_an_err;
   logic             glyph_err;
   logic             stall;

   modport master (
      output seg, an,
      input  frame_digits, frame_blank, frame_valid, frame_count,
             multi_an_err, glyph_err, stall
   );

   modport slave (
      input  seg, an,
      output frame_digits, frame_blank, frame_valid, frame_count,
             multi_an_err, glyph_err, stall
   );

endinterface

// File: rtl/sevenseg_glyph_decode.sv
// rtl/sevenseg_glyph_decode.sv - combinational 7-segment glyph to BCD decoder
// Purpose: maps an active-low segment pattern to its BCD value; flags blank and
//          any pattern that is not a legal digit or blank.
// Ports:   i_seg[6:0]  {g,f,e,d,c,b,a}, active-low
//          o_legal     pattern is a digit 0-9 or blank
//          o_blank     pattern is blank (all segments off)
//          o_bcd[3:0]  decoded value; 4'hF for blank or illegal
module sevenseg_glyph_decode
   import sevenseg_pkg::*;
(
   input  logic [SEG_W-1:0] i_seg,
   output logic             o_legal,
   output logic             o_blank,
   output logic [3:0]       o_bcd
);

   always_comb begin
      o_legal = 1'b1;
      o_blank = 1'b0;
      o_bcd   = DIGIT_BLANK;
      case (i_seg)
         GLYPH_0:     o_bcd = 4'd0;
         GLYPH_1:     o_bcd = 4'd1;
         GLYPH_2:     o_bcd = 4'd2;
         GLYPH_3:     o_bcd = 4'd3;
         GLYPH_4:     o_bcd = 4'd4;
         GLYPH_5:     o_bcd = 4'd5;
         GLYPH_6:     o_bcd = 4'd6;
         GLYPH_7:     o_bcd = 4'd7;
         GLYPH_8:     o_bcd = 4'd8;
         GLYPH_9:     o_bcd = 4'd9;
         GLYPH_BLANK: o_blank = 1'b1;
         default:     o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/sevenseg_frame_decoder.sv
// rtl/sevenseg_frame_decoder.sv - read back a multiplexed 7-segment display as BCD frames
// Purpose: samples {an,seg}, captures a digit once the lines have been stable for
//          STABLE_CYCLES, decodes it, and emits a 4-digit frame once every anode has
//          been seen. Tracks sticky error flags and a capture timeout.
// Ports:   clk    system clock
//          reset  asynchronous, active-high
//          bus    sevenseg_frame_decoder_if.slave (display inputs, frame/status outputs)
module sevenseg_frame_decoder
   import sevenseg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int CNT_W          = 21
) (
   input logic                     clk,
   input logic                     reset,
   sevenseg_frame_decoder_if.slave bus
);

   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_MAX     = CNT_W'(TIMEOUT_CYCLES);

   logic [AN_W-1:0]  r_s_an;
   logic [SEG_W-1:0] r_s_seg;
   logic [CNT_W-1:0] r_stab_cnt;
   logic [CNT_W-1:0] r_to_cnt;
   logic [3:0]       r_seen_mask;
   logic [3:0][3:0]  r_work_digit;
   logic [3:0]       r_work_blank;

   logic [15:0]      r_frame_digits;
   logic [3:0]       r_frame_blank;
   logic             r_frame_valid;
   logic [15:0]      r_frame_count;
   logic             r_multi_an_err;
   logic             r_glyph_err;
   logic             r_stall;

   logic             w_same;
   logic             w_capture;
   logic [2:0]       w_n_low;
   logic             w_single;
   logic             w_multi;
   logic [1:0]       w_idx;
   logic             w_dec_legal;
   logic             w_dec_blank;
   logic [3:0]       w_dec_bcd;
   logic             w_legal_cap;
   logic [3:0]       w_next_mask;
   logic [3:0][3:0]  w_next_digit;
   logic [3:0]       w_next_blank;
   logic             w_frame_done;
   logic [CNT_W-1:0] w_to_next;

   sevenseg_glyph_decode u_glyph (
      .i_seg   (r_s_seg),
      .o_legal (w_dec_legal),
      .o_blank (w_dec_blank),
      .o_bcd   (w_dec_bcd)
   );

   // Capture fires on the single edge where the counter reaches STABLE_CYCLES;
   // saturation guarantees one capture per stable episode.
   assign w_same    = ({bus.an, bus.seg} == {r_s_an, r_s_seg});
   assign w_capture = w_same && (r_stab_cnt == STABLE_M1);

   assign w_n_low  = count_low(r_s_an);
   assign w_single = (w_n_low == 3'd1);
   assign w_multi  = (w_n_low >= 3'd2);

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < AN_W; i++) begin
         if (!r_s_an[i]) w_idx = 2'(i);
      end
   end

   assign w_legal_cap = w_capture && w_single && w_dec_legal;
   assign w_next_mask = r_seen_mask | (4'b0001 << w_idx);

   // Working set including the digit being captured, so a completing capture
   // publishes its own digit on the same edge.
   always_comb begin
      w_next_digit = r_work_digit;
      w_next_blank = r_work_blank;
      if (w_legal_cap) begin
         w_next_digit[w_idx] = w_dec_bcd;
         w_next_blank[w_idx] = w_dec_blank;
      end
   end

   assign w_frame_done = w_legal_cap && (w_next_mask == 4'hF);

   // Any single-anode capture (legal or not) proves the display is scanning.
   assign w_to_next = (w_capture && w_single) ? '0 :
                      (r_to_cnt == TO_MAX)    ? r_to_cnt :
                                                r_to_cnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s_an         <= '1;
         r_s_seg        <= '1;
         r_stab_cnt     <= '0;
         r_to_cnt       <= '0;
         r_seen_mask    <= '0;
         r_work_digit   <= '0;
         r_work_blank   <= '0;
         r_frame_digits <= '0;
         r_frame_blank  <= '0;
         r_frame_valid  <= 1'b0;
         r_frame_count  <= '0;
         r_multi_an_err <= 1'b0;
         r_glyph_err    <= 1'b0;
         r_stall        <= 1'b0;
      end else begin
         r_s_an  <= bus.an;
         r_s_seg <= bus.seg;

         if (!w_same) begin
            r_stab_cnt <= '0;
         end else if (r_stab_cnt != STABLE_MAX) begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
         end

         r_frame_valid <= 1'b0;

         if (w_capture && w_single) begin
            if (w_dec_legal) begin
               r_work_digit <= w_next_digit;
               r_work_blank <= w_next_blank;
               if (w_frame_done) begin
                  r_seen_mask    <= '0;
                  r_frame_digits <= w_next_digit;
                  r_frame_blank  <= w_next_blank;
                  r_frame_valid  <= 1'b1;
                  r_frame_count  <= r_frame_count + 16'd1;
               end else begin
                  r_seen_mask <= w_next_mask;
               end
            end else begin
               r_glyph_err <= 1'b1;
            end
         end else if (w_capture && w_multi) begin
            r_multi_an_err <= 1'b1;
         end

         r_to_cnt <= w_to_next;
         r_stall  <= (w_to_next == TO_MAX);
      end
   end

   assign bus.frame_digits = r_frame_digits;
   assign bus.frame_blank  = r_frame_blank;
   assign bus.frame_valid  = r_frame_valid;
   assign bus.frame_count  = r_frame_count;
   assign bus.multi_an_err = r_multi_an_err;
   assign bus.glyph_err    = r_glyph_err;
   assign bus.stall        = r_stall;

endmodule

// File: tb/tb_sevenseg_frame_decoder.sv
// tb/tb_sevenseg_frame_decoder.sv - scoreboard bench for the 7-segment frame decoder
module tb_sevenseg_frame_decoder;

   localparam int S = 16;
   localparam int T = 64;

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  blank;
      logic [15:0] count;
   } frame_t;

   logic clk;
   logic reset;

   sevenseg_frame_decoder_if u_if ();

   sevenseg_frame_decoder #(
      .STABLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T),
      .CNT_W          (21)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   frame_t exp_q[$];

   logic [6:0] glyph_tab [10];

   // Reference model state: what the display has shown, in terms of digits.
   int          m_digit [4];
   logic [3:0]  m_blank;
   logic [3:0]  m_seen;
   logic [15:0] m_count;
   logic        m_multi;
   logic        m_glyph;
   logic [10:0] m_prev;
   int          m_run;
   int          m_since;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_digit[i] = 0;
      m_blank = '0;
      m_seen  = '0;
      m_count = '0;
      m_multi = 1'b0;
      m_glyph = 1'b0;
      m_prev  = {4'hF, 7'h7F};
      m_run   = 1;
      m_since = 0;
   endtask

   task automatic model_capture(input logic [3:0] a, input logic [6:0] s);
      int nlow;
      int idx;
      int val;
      frame_t f;
      nlow = $countones(~a);
      if (nlow == 0) return;
      if (nlow >= 2) begin
         m_multi = 1'b1;
         return;
      end
      idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      val = -1;
      if (s == 7'h7F) val = 15;
      for (int v = 0; v < 10; v++) if (glyph_tab[v] == s) val = v;
      if (val < 0) begin
         m_glyph = 1'b1;
         return;
      end
      m_digit[idx] = val;
      m_blank[idx] = (val == 15);
      m_seen[idx]  = 1'b1;
      if (m_seen == 4'hF) begin
         m_count  = m_count + 16'd1;
         f.digits = {4'(m_digit[3]), 4'(m_digit[2]), 4'(m_digit[1]), 4'(m_digit[0])};
         f.blank  = m_blank;
         f.count  = m_count;
         exp_q.push_back(f);
         m_seen = '0;
      end
   endtask

   // Hold {a,s} for n clock edges; predict captures from run length alone.
   task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
      logic [10:0] key;
      int old_run;
      int k;
      bit cap;
      key     = {a, s};
      old_run = (key == m_prev) ? m_run : 0;
      m_prev  = key;
      m_run   = old_run + n;
      cap     = (old_run < S + 1) && (m_run >= S + 1);
      k       = S + 1 - old_run;
      if (cap) model_capture(a, s);
      if (cap && $countones(~a) == 1) m_since = n - k;
      else m_since = m_since + n;
      u_if.an  = a;
      u_if.seg = s;
      repeat (n) @(posedge clk);
      #1;
      chk("stall", {31'd0, u_if.stall}, {31'd0, m_since >= T});
      chk("multi_an_err", {31'd0, u_if.multi_an_err}, {31'd0, m_multi});
      chk("glyph_err", {31'd0, u_if.glyph_err}, {31'd0, m_glyph});
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_digits"}, {16'd0, u_if.frame_digits}, 32'd0);
      chk({tag, "_blank"}, {28'd0, u_if.frame_blank}, 32'd0);
      chk({tag, "_valid"}, {31'd0, u_if.frame_valid}, 32'd0);
      chk({tag, "_count"}, {16'd0, u_if.frame_count}, 32'd0);
      chk({tag, "_errs"}, {30'd0, u_if.multi_an_err, u_if.glyph_err}, 32'd0);
      chk({tag, "_stall"}, {31'd0, u_if.stall}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check_zero_outputs("reset");
      #1 reset = 1'b0;
      model_reset();
   endtask

   function automatic logic [6:0] gl(input int v);
      logic [6:0] g;
      g = (v == 15) ? 7'h7F : glyph_tab[v];
      return g;
   endfunction

   // Monitor: every frame pulse must match the oldest predicted frame.
   always @(negedge clk) begin
      frame_t f;
      if (!reset && u_if.frame_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", {16'd0, u_if.frame_count}, 32'hFFFF_FFFF);
         end else begin
            f = exp_q.pop_front();
            chk("frame_digits", {16'd0, u_if.frame_digits}, {16'd0, f.digits});
            chk("frame_blank", {28'd0, u_if.frame_blank}, {28'd0, f.blank});
            chk("frame_count", {16'd0, u_if.frame_count}, {16'd0, f.count});
         end
      end
   end

   initial begin
      int order [4];
      int tmp;
      int j;
      int v;
      logic [6:0] gs;

      glyph_tab[0] = 7'b1000000; glyph_tab[1] = 7'b1111001;
      glyph_tab[2] = 7'b0100100; glyph_tab[3] = 7'b0110000;
      glyph_tab[4] = 7'b0011001; glyph_tab[5] = 7'b0010010;
      glyph_tab[6] = 7'b0000010; glyph_tab[7] = 7'b1111000;
      glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0010000;

      reset    = 1'b1;
      u_if.an  = 4'hF;
      u_if.seg = 7'h7F;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_zero_outputs("init");
      reset = 1'b0;

      // 1: clean scan 1,2,3,4 -> 16'h4321
      for (int i = 0; i < 4; i++) show(~(4'b1 << i), gl(i + 1), 20);
      @(negedge clk);
      chk("t1_frames_left", exp_q.size(), 0);
      chk("t1_count", {16'd0, u_if.frame_count}, 32'd1);
      chk("t1_digits", {16'd0, u_if.frame_digits}, 32'h4321);

      // 2: 15-cycle dwell is too short to capture
      show(4'b1110, gl(1), 15);
      show(4'b1101, gl(2), 20);
      show(4'b1011, gl(3), 20);
      show(4'b0111, gl(4), 20);
      show(4'b1110, gl(7), 20);

      // 3: one-cycle glitch inside a dwell
      show(4'b1101, gl(9), 5);
      show(4'b1101, gl(8), 1);
      show(4'b1101, gl(9), 20);

      // 4: two anodes on together
      show(4'b1100, gl(0), 20);
      for (int i = 0; i < 4; i++) show(~(4'b1 << i), gl(i), 20);

      // 5: blank digit, then an illegal glyph
      show(4'b1110, gl(5), 20);
      show(4'b1101, gl(6), 20);
      show(4'b1011, 7'h7F, 20);
      show(4'b0111, gl(8), 20);
      @(negedge clk);
      chk("t5_digits", {16'd0, u_if.frame_digits}, 32'h8F65);
      chk("t5_blank", {28'd0, u_if.frame_blank}, 32'b0100);
      show(4'b1110, 7'b0111111, 20);

      // random scans
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 4; i++) order[i] = i;
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
         end
         for (int i = 0; i < 4; i++) begin
            v  = ($urandom_range(9, 0) == 0) ? 15 : $urandom_range(9, 0);
            gs = gl(v);
            if ($urandom_range(3, 0) == 0) begin
               show(~(4'b1 << order[i]), gs, $urandom_range(8, 1));
               show(~(4'b1 << order[i]), gs ^ (7'b1 << $urandom_range(6, 0)), 1);
            end
            show(~(4'b1 << order[i]), gs, $urandom_range(24, 14));
            if ($urandom_range(9, 0) < 3) show(4'hF, 7'h7F, $urandom_range(40, 1));
         end
      end

      // 6: timeout with all anodes off, then a capture clears stall
      do_reset();
      show(4'hF, 7'h7F, 63);
      show(4'hF, 7'h7F, 1);
      show(4'hF, 7'h7F, 36);
      show(4'b1110, gl(3), 16);
      show(4'b1110, gl(3), 1);
      show(4'b1101, gl(1), 20);
      do_reset();
      show(4'b1011, gl(2), 20);
      show(4'b0111, gl(6), 20);
      show(4'b1110, gl(4), 20);
      show(4'b1101, gl(0), 20);
      @(negedge clk);
      chk("t6_count", {16'd0, u_if.frame_count}, 32'd1);
      chk("t6_digits", {16'd0, u_if.frame_digits}, 32'h6204);
      chk("frames_pending", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
